pn_expr_tx: RTL and testbench
=============================

Name: pn_expr_tx

Overview:
Stimulus transmitter for the Polish Notation evaluator interface. It buffers a token string loaded by a host, then serializes it onto the evaluator's input protocol (mode, operator, in, in_valid). It then collects the evaluator's out_valid/out result burst and reports results or a timeout. It sits between the test/host controller and the PN evaluator as the driving end of that interface.

Parameters:
MAX_TOKENS, 16, token buffer depth (max expression length)
NUM_RESULTS, 4, max results captured per transaction
TIMEOUT, 30, cycles to wait for first out_valid before error

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  reset; synchronous, active-high (asserted = 1; name kept as in codebase)
load_valid  in  1  host token write strobe
load_ready  out  1  buffer accepts token this cycle
load_operator  in  1  token is operator (1) / operand (0)
load_val  in  3  operand value or operator code
load_last  in  1  final token of expression
start  in  1  launch transmission (sampled in READY only)
start_mode  in  2  mode code driven to evaluator
busy  out  1  high in SEND, WAIT_RESP, COLLECT
mode  out  2  evaluator mode
operator  out  1  evaluator token type
in  out  3  evaluator token value
in_valid  out  1  evaluator token strobe
out_valid  in  1  evaluator result strobe
out  in  32  evaluator result, signed
res_valid  out  1  captured-result strobe
res_data  out  32  captured result, signed
res_idx  out  2  index of captured result
res_count  out  3  results captured (valid with done)
res_ovf  out  1  more than NUM_RESULTS results seen (valid with done)
timeout_err  out  1  no response within TIMEOUT (valid with done)
done  out  1  one-cycle transaction-complete pulse

Behaviour:
- All outputs registered. Reset: state IDLE, wr_cnt=0, rd_cnt=0, all outputs 0 except load_ready=1 (asserted the cycle after reset releases). Reset mid-operation aborts immediately; the next cycle has in_valid=0. Buffer contents are don't-care after reset.
- Token buffer: MAX_TOKENS x 4 bits {operator,val}. wr_cnt is 0..MAX_TOKENS (5 bits).
- IDLE: load_ready = (wr_cnt < MAX_TOKENS). An accept writes buf[wr_cnt] and increments wr_cnt. Accepting with load_last, or accepting the MAX_TOKENS-th token, moves to READY; load_ready=0 from the next cycle. start in IDLE is ignored.
- READY: load_ready=0, load_valid ignored. start=1 latches start_mode and moves to SEND; rd_cnt=0.
- SEND: the first in_valid=1 occurs in the cycle after start is sampled. in_valid stays high for exactly wr_cnt consecutive cycles, with operator/in = buf[rd_cnt] and rd_cnt incrementing. mode holds the latched code for every SEND cycle. After the last token, go to WAIT_RESP; in_valid=0 and operator/in/mode=0 from then on.
- WAIT_RESP: wait_cnt increments each cycle from 0.
  - out_valid=1 -> COLLECT, and this cycle's out is captured.
  - wait_cnt reaching TIMEOUT with no out_valid -> DONE with timeout_err=1, res_count=0.
  - out_valid in the same cycle as the timeout boundary wins (capture, no error).
- COLLECT: each out_valid=1 cycle with res_count < NUM_RESULTS produces, next cycle, res_valid=1, res_data=out, res_idx=res_count; res_count then increments. Once res_count = NUM_RESULTS, further out_valid cycles are not captured and set sticky res_ovf. out_valid=0 -> DONE.
- DONE: done=1 for one cycle. res_count, res_ovf and timeout_err hold until the next start. Then go to IDLE with wr_cnt=0 and load_ready=1.
- out is passed through unchanged as a 32-bit signed value; no width conversion.
- Mode codes: 0 prefix-burst, 1 postfix-burst, 2 prefix, 3 postfix. They are passed through unchanged; the block does not interpret them.

Decomposition:
- Shared package pn_pkg: mode code constants, operator codes (ADD=0, SUB=1, MULT=2, ABS=3), token width (4), the state enum, and the MAX_TOKENS/NUM_RESULTS defaults shared with the evaluator.
- One sub-module is natural: pn_token_buf, a simple write-pointer/read-pointer register file with full flag.

Test Plan:
- Load (0,3),(0,4),(1,0)+last; start, start_mode=3 -> in_valid high 3 cycles beginning the cycle after start; in=3,4,0; operator=0,0,1; mode=3.
- Continue: model asserts out_valid 1 cycle with out=7 five cycles after last token -> res_valid with res_data=7, res_idx=0; done pulse; res_count=1, timeout_err=0, res_ovf=0.
- Same load, model never responds -> done exactly TIMEOUT cycles into WAIT_RESP; timeout_err=1, res_count=0.
- Load 16 tokens without last -> load_ready falls after 16th accept; a 17th load_valid is ignored; start yields 16 consecutive in_valid cycles in buffer order.
- Model returns out_valid for 6 consecutive cycles with out=-1,2,-3,4,5,6 -> 4 res_valid pulses (-1,2,-3,4), res_count=4, res_ovf=1.
- Assert rst_n=1 during the 2nd SEND cycle -> next cycle in_valid=0, busy=0, load_ready=1 after release; a start before any load is ignored.

Source files
------------

// File: rtl/pn_pkg.sv
// Shared definitions for the Polish Notation evaluator and its stimulus transmitter.
package pn_pkg;

    localparam int TOKEN_W         = 4;
    localparam int MAX_TOKENS_DEF  = 16;
    localparam int NUM_RESULTS_DEF = 4;
    localparam int TIMEOUT_DEF     = 30;

    localparam logic [1:0] MODE_PREFIX_BURST  = 2'd0;
    localparam logic [1:0] MODE_POSTFIX_BURST = 2'd1;
    localparam logic [1:0] MODE_PREFIX        = 2'd2;
    localparam logic [1:0] MODE_POSTFIX       = 2'd3;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_MULT = 3'd2;
    localparam logic [2:0] OP_ABS  = 3'd3;

    typedef struct packed {
        logic       op;
        logic [2:0] val;
    } token_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READY,
        ST_SEND,
        ST_WAIT_RESP,
        ST_COLLECT,
        ST_DONE
    } tx_state_t;

    function automatic token_t make_token(input logic op, input logic [2:0] val);
        token_t t;
        t.op  = op;
        t.val = val;
        return t;
    endfunction

endpackage

// File: rtl/pn_expr_tx_if.sv
// Token/result bus between the transmitter (master) and the PN evaluator (slave).
interface pn_expr_tx_if;
    import pn_pkg::*;

    logic [1:0]         mode;
    logic               operator;
    logic [2:0]         in;
    logic               in_valid;
    logic               out_valid;
    logic signed [31:0] out;

    modport master (
        output mode, operator, in, in_valid,
        input  out_valid, out
    );

    modport slave (
        input  mode, operator, in, in_valid,
        output out_valid, out
    );

endinterface

// File: rtl/pn_token_buf.sv
// Token store for one expression: written in order by the host, read back in order while sending.
module pn_token_buf
    import pn_pkg::*;
#(
    parameter  int DEPTH = MAX_TOKENS_DEF,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             wr_en,
    input  token_t           wr_data,
    input  logic             rd_en,
    output token_t           rd_data,
    output logic [CNT_W-1:0] wr_cnt,
    output logic [CNT_W-1:0] rd_cnt,
    output logic             full
);

    logic [TOKEN_W-1:0] mem [DEPTH];

    assign full    = (wr_cnt == CNT_W'(DEPTH));
    assign rd_data = token_t'(mem[rd_cnt[IDX_W-1:0]]);

    always_ff @(posedge clk) begin
        if (rst_n || clr) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            if (wr_en && !full) begin
                wr_cnt <= wr_cnt + 1'b1;
            end
            if (rd_en && (rd_cnt < wr_cnt)) begin
                rd_cnt <= rd_cnt + 1'b1;
            end
        end
    end

    // Storage needs no reset: contents are only read below wr_cnt.
    always_ff @(posedge clk) begin
        if (wr_en && !full) begin
            mem[wr_cnt[IDX_W-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/pn_expr_tx.sv
// Buffers a host-loaded PN token string, serializes it to the evaluator and collects its result burst.
module pn_expr_tx
    import pn_pkg::*;
#(
    parameter int MAX_TOKENS  = MAX_TOKENS_DEF,
    parameter int NUM_RESULTS = NUM_RESULTS_DEF,
    parameter int TIMEOUT     = TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_valid,
    output logic               load_ready,
    input  logic               load_operator,
    input  logic [2:0]         load_val,
    input  logic               load_last,
    input  logic               start,
    input  logic [1:0]         start_mode,
    output logic               busy,
    output logic               res_valid,
    output logic signed [31:0] res_data,
    output logic [1:0]         res_idx,
    output logic [2:0]         res_count,
    output logic               res_ovf,
    output logic               timeout_err,
    output logic               done,
    pn_expr_tx_if.master       eval
);

    localparam int CNT_W  = $clog2(MAX_TOKENS + 1);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    tx_state_t          state, state_d;
    logic [WAIT_W-1:0]  wait_cnt, wait_cnt_d;
    logic [CNT_W-1:0]   wr_cnt, rd_cnt;
    logic               full;
    token_t             wr_token, rd_data;
    logic               buf_wr, buf_rd, buf_clr;
    logic               result_slot;

    logic               load_ready_d, busy_d, in_valid_d, operator_d;
    logic               res_valid_d, res_ovf_d, timeout_err_d, done_d;
    logic [1:0]         mode_d, res_idx_d;
    logic [2:0]         in_d, res_count_d;
    logic signed [31:0] res_data_d;

    assign wr_token    = make_token(load_operator, load_val);
    assign result_slot = (res_count < 3'(NUM_RESULTS));

    pn_token_buf #(
        .DEPTH (MAX_TOKENS)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (buf_clr),
        .wr_en   (buf_wr),
        .wr_data (wr_token),
        .rd_en   (buf_rd),
        .rd_data (rd_data),
        .wr_cnt  (wr_cnt),
        .rd_cnt  (rd_cnt),
        .full    (full)
    );

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_d;
            wait_cnt <= wait_cnt_d;
        end
    end

    // Every output is computed one cycle ahead here and registered below.
    always_comb begin
        state_d       = state;
        wait_cnt_d    = wait_cnt;
        load_ready_d  = 1'b0;
        mode_d        = '0;
        operator_d    = 1'b0;
        in_d          = '0;
        in_valid_d    = 1'b0;
        res_valid_d   = 1'b0;
        res_data_d    = res_data;
        res_idx_d     = res_idx;
        res_count_d   = res_count;
        res_ovf_d     = res_ovf;
        timeout_err_d = timeout_err;
        done_d        = 1'b0;
        buf_wr        = 1'b0;
        buf_rd        = 1'b0;
        buf_clr       = 1'b0;

        unique case (state)
            ST_IDLE: begin
                load_ready_d = !full;
                if (load_valid && load_ready && !full) begin
                    buf_wr = 1'b1;
                    if (load_last || (wr_cnt == CNT_W'(MAX_TOKENS - 1))) begin
                        state_d      = ST_READY;
                        load_ready_d = 1'b0;
                    end
                end
            end
            ST_READY: begin
                if (start) begin
                    state_d       = ST_SEND;
                    mode_d        = start_mode;
                    operator_d    = rd_data.op;
                    in_d          = rd_data.val;
                    in_valid_d    = 1'b1;
                    buf_rd        = 1'b1;
                    res_count_d   = '0;
                    res_ovf_d     = 1'b0;
                    timeout_err_d = 1'b0;
                end
            end
            ST_SEND: begin
                if (rd_cnt < wr_cnt) begin
                    mode_d     = eval.mode;
                    operator_d = rd_data.op;
                    in_d       = rd_data.val;
                    in_valid_d = 1'b1;
                    buf_rd     = 1'b1;
                end else begin
                    state_d    = ST_WAIT_RESP;
                    wait_cnt_d = '0;
                end
            end
            ST_WAIT_RESP: begin
                wait_cnt_d = wait_cnt + 1'b1;
                if (eval.out_valid) begin
                    state_d = ST_COLLECT;
                end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
                    state_d       = ST_DONE;
                    timeout_err_d = 1'b1;
                    done_d        = 1'b1;
                end
            end
            ST_COLLECT: begin
                if (!eval.out_valid) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            ST_DONE: begin
                state_d      = ST_IDLE;
                load_ready_d = 1'b1;
                buf_clr      = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        // The first result arrives in WAIT_RESP, the rest in COLLECT; both capture the same way.
        if (((state == ST_WAIT_RESP) || (state == ST_COLLECT)) && eval.out_valid) begin
            if (result_slot) begin
                res_valid_d = 1'b1;
                res_data_d  = eval.out;
                res_idx_d   = res_count[1:0];
                res_count_d = res_count + 3'd1;
            end else begin
                res_ovf_d = 1'b1;
            end
        end

        busy_d = (state_d == ST_SEND) || (state_d == ST_WAIT_RESP) || (state_d == ST_COLLECT);
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            load_ready    <= 1'b1;
            busy          <= 1'b0;
            eval.mode     <= '0;
            eval.operator <= 1'b0;
            eval.in       <= '0;
            eval.in_valid <= 1'b0;
            res_valid     <= 1'b0;
            res_data      <= '0;
            res_idx       <= '0;
            res_count     <= '0;
            res_ovf       <= 1'b0;
            timeout_err   <= 1'b0;
            done          <= 1'b0;
        end else begin
            load_ready    <= load_ready_d;
            busy          <= busy_d;
            eval.mode     <= mode_d;
            eval.operator <= operator_d;
            eval.in       <= in_d;
            eval.in_valid <= in_valid_d;
            res_valid     <= res_valid_d;
            res_data      <= res_data_d;
            res_idx       <= res_idx_d;
            res_count     <= res_count_d;
            res_ovf       <= res_ovf_d;
            timeout_err   <= timeout_err_d;
            done          <= done_d;
        end
    end

endmodule

// File: tb/tb_pn_expr_tx.sv
// Randomized bench for pn_expr_tx: a transaction-level model predicts the token stream and result timing.
module tb_pn_expr_tx;
    import pn_pkg::*;

    localparam int MAXT = 16;
    localparam int NRES = 4;
    localparam int TMO  = 30;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               load_valid, load_ready, load_operator, load_last;
    logic [2:0]         load_val;
    logic               start;
    logic [1:0]         start_mode;
    logic               busy, res_valid, res_ovf, timeout_err, done;
    logic signed [31:0] res_data;
    logic [1:0]         res_idx;
    logic [2:0]         res_count;

    pn_expr_tx_if eval_bus ();

    pn_expr_tx #(
        .MAX_TOKENS  (MAXT),
        .NUM_RESULTS (NRES),
        .TIMEOUT     (TMO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .load_valid    (load_valid),
        .load_ready    (load_ready),
        .load_operator (load_operator),
        .load_val      (load_val),
        .load_last     (load_last),
        .start         (start),
        .start_mode    (start_mode),
        .busy          (busy),
        .res_valid     (res_valid),
        .res_data      (res_data),
        .res_idx       (res_idx),
        .res_count     (res_count),
        .res_ovf       (res_ovf),
        .timeout_err   (timeout_err),
        .done          (done),
        .eval          (eval_bus)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    logic               tok_op  [MAXT];
    logic [2:0]         tok_val [MAXT];
    int                 resp_delay;
    int                 resp_n;
    logic signed [31:0] resp_out [8];

    task automatic checkOutput(input string tag, input logic signed [31:0] actual,
                               input logic signed [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // One full transaction: load, start, token stream, response, done.
    task automatic applyStimulus(input int len, input bit use_last, input logic [1:0] md,
                                 input bit try_extra);
        bit capture;
        int exp_done, n_cap, pulses, done_at;

        checkOutput("idle_load_ready", load_ready, 1);
        for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                load_valid = 1'b0;
                @(negedge clk);
                checkOutput("load_ready_gap", load_ready, 1);
            end
            load_valid    = 1'b1;
            load_operator = tok_op[i];
            load_val      = tok_val[i];
            load_last     = use_last && (i == len - 1);
            @(negedge clk);
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        checkOutput("load_ready_after_last", load_ready, 0);

        if (try_extra) begin
            load_valid    = 1'b1;
            load_operator = 1'($urandom_range(0, 1));
            load_val      = 3'($urandom_range(0, 7));
            @(negedge clk);
            load_valid = 1'b0;
            checkOutput("load_ready_in_ready", load_ready, 0);
        end
        repeat ($urandom_range(0, 2)) @(negedge clk);
        checkOutput("busy_before_start", busy, 0);

        start      = 1'b1;
        start_mode = md;
        @(negedge clk);
        start      = 1'b0;
        start_mode = 2'($urandom_range(0, 3));

        for (int i = 0; i < len; i++) begin
            checkOutput("in_valid", eval_bus.in_valid, 1);
            checkOutput("token_operator", eval_bus.operator, tok_op[i]);
            checkOutput("token_in", eval_bus.in, tok_val[i]);
            checkOutput("mode", eval_bus.mode, md);
            checkOutput("busy_send", busy, 1);
            @(negedge clk);
        end
        checkOutput("in_valid_after_send", eval_bus.in_valid, 0);
        checkOutput("mode_after_send", eval_bus.mode, 0);
        checkOutput("busy_wait", busy, 1);

        capture  = (resp_delay >= 0) && (resp_delay < TMO);
        exp_done = capture ? resp_delay + resp_n + 1 : TMO;
        n_cap    = capture ? ((resp_n < NRES) ? resp_n : NRES) : 0;
        pulses   = 0;
        done_at  = -1;

        for (int c = 0; c <= exp_done + 1; c++) begin
            if (res_valid === 1'b1) begin
                if (pulses < n_cap) begin
                    checkOutput("res_data", res_data, resp_out[pulses]);
                    checkOutput("res_idx", res_idx, pulses);
                end
                pulses++;
                checkOutput("res_valid_cycle", c, resp_delay + pulses);
            end
            if ((done === 1'b1) && (done_at < 0)) done_at = c;
            if (c == exp_done) begin
                checkOutput("done_res_count", res_count, n_cap);
                checkOutput("done_res_ovf", res_ovf, (capture && resp_n > NRES) ? 1 : 0);
                checkOutput("done_timeout_err", timeout_err, capture ? 0 : 1);
                checkOutput("done_busy", busy, 0);
            end
            if (c == exp_done + 1) begin
                checkOutput("done_one_cycle", done, 0);
                checkOutput("load_ready_after_done", load_ready, 1);
                checkOutput("res_count_hold", res_count, n_cap);
                checkOutput("timeout_err_hold", timeout_err, capture ? 0 : 1);
            end
            if (capture && (c >= resp_delay) && (c < resp_delay + resp_n)) begin
                eval_bus.out_valid = 1'b1;
                eval_bus.out       = resp_out[c - resp_delay];
            end else begin
                eval_bus.out_valid = 1'b0;
                eval_bus.out       = $urandom;
            end
            @(negedge clk);
        end
        checkOutput("res_pulse_count", pulses, n_cap);
        checkOutput("done_cycle", done_at, exp_done);
    endtask

    task automatic randomTokens(input int len);
        for (int i = 0; i < len; i++) begin
            tok_op[i]  = 1'($urandom_range(0, 1));
            tok_val[i] = 3'($urandom_range(0, 7));
        end
    endtask

    initial begin
        int  len;
        bit  use_last;

        rst_n              = 1'b1;
        load_valid         = 1'b0;
        load_operator      = 1'b0;
        load_val           = '0;
        load_last          = 1'b0;
        start              = 1'b0;
        start_mode         = '0;
        eval_bus.out_valid = 1'b0;
        eval_bus.out       = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("reset_load_ready", load_ready, 1);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_in_valid", eval_bus.in_valid, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_res_count", res_count, 0);
        checkOutput("reset_timeout_err", timeout_err, 0);

        // Three-token expression with a single prompt result.
        tok_op[0] = 1'b0; tok_val[0] = 3'd3;
        tok_op[1] = 1'b0; tok_val[1] = 3'd4;
        tok_op[2] = 1'b1; tok_val[2] = OP_ADD;
        resp_delay = 4; resp_n = 1; resp_out[0] = 32'sd7;
        applyStimulus(3, 1'b1, MODE_POSTFIX, 1'b0);

        // Same expression, evaluator silent.
        resp_delay = -1; resp_n = 0;
        applyStimulus(3, 1'b1, MODE_POSTFIX, 1'b0);

        // Full buffer without last, extra token refused, overflowing result burst.
        randomTokens(MAXT);
        resp_delay = int'($urandom_range(0, 5)); resp_n = 6;
        resp_out[0] = -32'sd1; resp_out[1] = 32'sd2; resp_out[2] = -32'sd3;
        resp_out[3] = 32'sd4;  resp_out[4] = 32'sd5; resp_out[5] = 32'sd6;
        applyStimulus(MAXT, 1'b0, MODE_PREFIX_BURST, 1'b1);

        // Response arriving in the last waiting cycle beats the timeout.
        randomTokens(2);
        resp_delay = TMO - 1; resp_n = 2;
        resp_out[0] = 32'sd100; resp_out[1] = -32'sd100;
        applyStimulus(2, 1'b1, MODE_PREFIX, 1'b0);

        // Reset during the second send cycle, then a start with an empty buffer.
        randomTokens(3);
        for (int i = 0; i < 3; i++) begin
            load_valid    = 1'b1;
            load_operator = tok_op[i];
            load_val      = tok_val[i];
            load_last     = (i == 2);
            @(negedge clk);
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        start      = 1'b1;
        start_mode = MODE_PREFIX;
        @(negedge clk);
        start = 1'b0;
        checkOutput("abort_first_send", eval_bus.in_valid, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("abort_in_valid", eval_bus.in_valid, 0);
        checkOutput("abort_busy", busy, 0);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("abort_load_ready", load_ready, 1);
        start      = 1'b1;
        start_mode = MODE_POSTFIX_BURST;
        @(negedge clk);
        start = 1'b0;
        checkOutput("idle_start_busy", busy, 0);
        checkOutput("idle_start_in_valid", eval_bus.in_valid, 0);
        @(negedge clk);
        checkOutput("idle_start_in_valid2", eval_bus.in_valid, 0);
        checkOutput("idle_start_load_ready", load_ready, 1);

        for (int t = 0; t < 25; t++) begin
            len      = int'($urandom_range(1, MAXT));
            use_last = (len < MAXT) ? 1'b1 : 1'($urandom_range(0, 1));
            randomTokens(len);
            if ($urandom_range(0, 4) == 0) begin
                resp_delay = -1;
                resp_n     = 0;
            end else begin
                resp_delay = int'($urandom_range(0, TMO - 1));
                resp_n     = int'($urandom_range(1, 7));
                for (int j = 0; j < 8; j++) resp_out[j] = $urandom;
            end
            applyStimulus(len, use_last, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, limit %0d", 1000000);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
